fx_pc_sequencer: RTL and testbench

Parametrised successor to the R15 program-counter register in the GSU fetch path. Adds SuperFX-style delayed branches and LOOP with a single delay slot, an internal R12-style loop counter, and LINK address generation. Sits between the instruction decoder and the code cache/ROM address mux. Honours the cache-hold stall (cchld) in every state.

---
 rtl/fx_pc_sequencer.sv | 144 ++++++++++++++
 tb/tb_fx_pc_sequencer.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fx_pc_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fx_pc_sequencer : GSU fetch-path PC with delayed branch/LOOP, loop counter,
// LINK generation; optional return stack under FX_PC_STACK_EN. Rev 1.0
// ---------------------------------------------------------------------------
module fx_pc_sequencer #(
  parameter int ADDR_W      = 16,
  parameter int LOOP_W      = 16,
  parameter int STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cchld,
  input  logic              pcen,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_data,
  input  logic              loop_en,
  input  logic [ADDR_W-1:0] loop_target,
  input  logic              loop_cnt_wr,
  input  logic [LOOP_W-1:0] loop_cnt_data,
  input  logic              branch_en,
  input  logic              branch_cond,
  input  logic [7:0]        branch_off,
  input  logic              link_en,
  input  logic [2:0]        link_n,
  input  logic              call_en,
  input  logic              ret_en,
  output logic [ADDR_W-1:0] pc,
  output logic [LOOP_W-1:0] loop_cnt,
  output logic              loop_zero,
  output logic [ADDR_W-1:0] link_addr,
  output logic              redirect_pending,
  output logic              seq_err
);

  typedef enum logic [0:0] {IDLE = 1'b0, PENDING = 1'b1} state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_pend_target;
  logic [ADDR_W-1:0] w_pc_inc;
  logic [ADDR_W-1:0] w_branch_target;
  logic [LOOP_W-1:0] w_loop_dec;
  logic              w_load;
  logic              w_kill;
  logic              w_link_bad;
  logic              w_err;

  assign w_pc_inc        = pc + ADDR_W'(1);
  assign w_branch_target = pc + {{(ADDR_W-8){branch_off[7]}}, branch_off};
  assign w_loop_dec      = loop_cnt - LOOP_W'(1);
  assign w_load          = load_en | call_en;
  assign w_link_bad      = (link_n == 3'd0) || (link_n > 3'd4);
  assign loop_zero        = (loop_cnt == '0);
  assign redirect_pending = (r_state == PENDING);

`ifdef FX_PC_STACK_EN
  localparam int DW = $clog2(STACK_DEPTH + 1);
  logic [ADDR_W-1:0] r_stack [STACK_DEPTH];
  logic [DW-1:0]     r_depth;
  logic              w_pop;
  logic              w_pop_empty;

  assign w_pop       = ret_en & ~w_load;
  assign w_pop_empty = w_pop && (r_depth == '0);
  assign w_kill      = w_load | w_pop;
`else
  logic [1:0] w_unused_stack;
  assign w_unused_stack = {ret_en, (STACK_DEPTH > 0)};
  assign w_kill         = w_load;
`endif

  always_comb begin
    w_err = 1'b0;
    if (r_state == PENDING && (branch_en || loop_en)) w_err = 1'b1;
    if (r_state == IDLE && branch_en && loop_en)      w_err = 1'b1;
    if (link_en && w_link_bad)                        w_err = 1'b1;
`ifdef FX_PC_STACK_EN
    if (w_pop_empty)                                  w_err = 1'b1;
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc            <= '0;
      loop_cnt      <= '0;
      link_addr     <= '0;
      r_state       <= IDLE;
      r_pend_target <= '0;
      seq_err       <= 1'b0;
`ifdef FX_PC_STACK_EN
      r_depth <= '0;
      for (int i = 0; i < STACK_DEPTH; i++) r_stack[i] <= '0;
`endif
    end else if (!cchld) begin
      if (w_load) begin
        pc      <= load_data;
        r_state <= IDLE;
`ifdef FX_PC_STACK_EN
      end else if (w_pop) begin
        pc      <= w_pop_empty ? '0 : r_stack[0];
        r_state <= IDLE;
`endif
      end else if (r_state == PENDING && pcen) begin
        pc      <= r_pend_target;
        r_state <= IDLE;
      end else if (pcen) begin
        pc <= w_pc_inc;
      end

      // New redirects arm only from IDLE and never against a jump/return.
      if (r_state == IDLE && !w_kill) begin
        if (loop_en) begin
          if (!loop_cnt_wr && w_loop_dec != '0) begin
            r_pend_target <= loop_target;
            r_state       <= PENDING;
          end
        end else if (branch_en && branch_cond) begin
          r_pend_target <= w_branch_target;
          r_state       <= PENDING;
        end
      end

      if (loop_cnt_wr)                     loop_cnt <= loop_cnt_data;
      else if (loop_en && r_state == IDLE) loop_cnt <= w_loop_dec;

      if (link_en) link_addr <= pc + ADDR_W'(link_n);
      if (w_err)   seq_err   <= 1'b1;

`ifdef FX_PC_STACK_EN
      // Push shifts toward the bottom so a full stack drops its oldest entry.
      if (call_en) begin
        for (int i = STACK_DEPTH - 1; i > 0; i--) r_stack[i] <= r_stack[i-1];
        r_stack[0] <= w_pc_inc;
        if (r_depth != DW'(STACK_DEPTH)) r_depth <= r_depth + DW'(1);
      end else if (w_pop && !w_pop_empty) begin
        for (int i = 0; i < STACK_DEPTH - 1; i++) r_stack[i] <= r_stack[i+1];
        r_depth <= r_depth - DW'(1);
      end
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fx_pc_sequencer.sv
`default_nettype none
// tb_fx_pc_sequencer : directed self-checking bench for fx_pc_sequencer.
module tb_fx_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cchld, pcen, load_en, loop_en, loop_cnt_wr;
  logic        branch_en, branch_cond, link_en, call_en, ret_en;
  logic [15:0] load_data, loop_target, loop_cnt_data;
  logic [7:0]  branch_off;
  logic [2:0]  link_n;
  logic [15:0] pc, loop_cnt, link_addr;
  logic        loop_zero, redirect_pending, seq_err;

  int checks = 0;
  int fails  = 0;

  fx_pc_sequencer #(.ADDR_W(16), .LOOP_W(16), .STACK_DEPTH(4)) dut (
    .clk(clk), .reset_n(reset_n), .cchld(cchld), .pcen(pcen),
    .load_en(load_en), .load_data(load_data), .loop_en(loop_en),
    .loop_target(loop_target), .loop_cnt_wr(loop_cnt_wr),
    .loop_cnt_data(loop_cnt_data), .branch_en(branch_en),
    .branch_cond(branch_cond), .branch_off(branch_off), .link_en(link_en),
    .link_n(link_n), .call_en(call_en), .ret_en(ret_en), .pc(pc),
    .loop_cnt(loop_cnt), .loop_zero(loop_zero), .link_addr(link_addr),
    .redirect_pending(redirect_pending), .seq_err(seq_err)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    cchld = 0; pcen = 0; load_en = 0; loop_en = 0; loop_cnt_wr = 0;
    branch_en = 0; branch_cond = 0; link_en = 0; call_en = 0; ret_en = 0;
    load_data = 0; loop_target = 0; loop_cnt_data = 0; branch_off = 0;
    link_n = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 0;
    #3;
    reset_n = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic jump(input logic [15:0] a);
    load_en = 1; load_data = a;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (pc !== 16'h0 || loop_cnt !== 16'h0 || link_addr !== 16'h0 ||
        redirect_pending !== 1'b0 || seq_err !== 1'b0 || loop_zero !== 1'b1) begin
      fails++;
      $display("FAIL reset_state: pc=%h cnt=%h link=%h pend=%b err=%b z=%b",
               pc, loop_cnt, link_addr, redirect_pending, seq_err, loop_zero);
    end
  endtask

  task automatic test_async_reset();
    loop_cnt_wr = 1; loop_cnt_data = 16'h0005;
    jump(16'h1234);
    branch_en = 1; branch_cond = 1; branch_off = 8'h10;
    tick();
    checks++;
    if (pc !== 16'h1234 || redirect_pending !== 1'b1 || loop_cnt !== 16'h5) begin
      fails++;
      $display("FAIL async_setup: pc=%h pend=%b cnt=%h want 1234/1/0005",
               pc, redirect_pending, loop_cnt);
    end
    #2 reset_n = 0;
    #1;
    checks++;
    if (pc !== 16'h0 || loop_cnt !== 16'h0 || redirect_pending !== 1'b0) begin
      fails++;
      $display("FAIL async_reset: pc=%h cnt=%h pend=%b want 0/0/0",
               pc, loop_cnt, redirect_pending);
    end
    reset_n = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_branch();
    jump(16'h0100);
    branch_en = 1; branch_cond = 0; branch_off = 8'h40; pcen = 1;
    tick();
    checks++;
    if (pc !== 16'h0101 || redirect_pending !== 1'b0) begin
      fails++;
      $display("FAIL branch_not_taken: pc=%h pend=%b want 0101/0", pc, redirect_pending);
    end
    jump(16'h0100);
    branch_en = 1; branch_cond = 1; branch_off = 8'hFE; pcen = 1;
    tick();
    checks++;
    if (pc !== 16'h0101 || redirect_pending !== 1'b1) begin
      fails++;
      $display("FAIL branch_slot: pc=%h pend=%b want 0101/1", pc, redirect_pending);
    end
    pcen = 1;
    tick();
    checks++;
    if (pc !== 16'h00FE || redirect_pending !== 1'b0 || seq_err !== 1'b0) begin
      fails++;
      $display("FAIL branch_target: pc=%h pend=%b err=%b want 00FE/0/0",
               pc, redirect_pending, seq_err);
    end
  endtask

  task automatic test_loop();
    logic [15:0] exp_pc [3] = '{16'h0200, 16'h0200, 16'h0212};
    logic [15:0] exp_cnt [3] = '{16'h2, 16'h1, 16'h0};
    loop_cnt_wr = 1; loop_cnt_data = 16'h3;
    jump(16'h0210);
    for (int p = 0; p < 3; p++) begin
      loop_en = 1; loop_target = 16'h0200; pcen = 1;
      tick();
      checks++;
      if (loop_cnt !== exp_cnt[p] || pc !== 16'h0211 ||
          redirect_pending !== (p < 2)) begin
        fails++;
        $display("FAIL loop_issue%0d: cnt=%h pc=%h pend=%b want %h/0211/%b",
                 p, loop_cnt, pc, redirect_pending, exp_cnt[p], p < 2);
      end
      pcen = 1;
      tick();
      checks++;
      if (pc !== exp_pc[p]) begin
        fails++;
        $display("FAIL loop_pass%0d: pc=%h want %h", p, pc, exp_pc[p]);
      end
      if (p < 2) jump(16'h0210);
    end
    checks++;
    if (loop_zero !== 1'b1 || seq_err !== 1'b0) begin
      fails++;
      $display("FAIL loop_zero: z=%b err=%b want 1/0", loop_zero, seq_err);
    end
    loop_cnt_wr = 1; loop_cnt_data = 16'h0007; loop_en = 1; loop_target = 16'h0300;
    tick();
    checks++;
    if (loop_cnt !== 16'h0007 || redirect_pending !== 1'b0) begin
      fails++;
      $display("FAIL loop_wr_wins: cnt=%h pend=%b want 0007/0", loop_cnt, redirect_pending);
    end
  endtask

  task automatic test_hold();
    do_reset();
    jump(16'h0400);
    branch_en = 1; branch_cond = 1; branch_off = 8'h20;
    tick();
    for (int c = 0; c < 5; c++) begin
      cchld = 1; pcen = 1; load_en = 1; load_data = 16'hDEAD; branch_en = 1;
      loop_cnt_wr = 1; loop_cnt_data = 16'h9;
      tick();
    end
    checks++;
    if (pc !== 16'h0400 || redirect_pending !== 1'b1 || seq_err !== 1'b0 ||
        loop_cnt !== 16'h0) begin
      fails++;
      $display("FAIL hold: pc=%h pend=%b err=%b cnt=%h want 0400/1/0/0000",
               pc, redirect_pending, seq_err, loop_cnt);
    end
    branch_en = 1; branch_cond = 1; branch_off = 8'h7F;
    tick();
    checks++;
    if (seq_err !== 1'b1 || redirect_pending !== 1'b1) begin
      fails++;
      $display("FAIL branch_in_pending: err=%b pend=%b want 1/1", seq_err, redirect_pending);
    end
    pcen = 1;
    tick();
    checks++;
    if (pc !== 16'h0420 || redirect_pending !== 1'b0) begin
      fails++;
      $display("FAIL hold_release: pc=%h pend=%b want 0420/0", pc, redirect_pending);
    end
    jump(16'h0500);
    tick();
    checks++;
    if (seq_err !== 1'b1) begin
      fails++;
      $display("FAIL err_sticky: err=%b want 1", seq_err);
    end
  endtask

  task automatic test_wrap_link();
    do_reset();
    jump(16'hFFFF);
    pcen = 1;
    tick();
    checks++;
    if (pc !== 16'h0000) begin
      fails++;
      $display("FAIL pc_wrap: pc=%h want 0000", pc);
    end
    jump(16'h0010);
    link_en = 1; link_n = 3'd4; pcen = 1;
    tick();
    checks++;
    if (link_addr !== 16'h0014 || pc !== 16'h0011 || seq_err !== 1'b0) begin
      fails++;
      $display("FAIL link4: link=%h pc=%h err=%b want 0014/0011/0",
               link_addr, pc, seq_err);
    end
    link_en = 1; link_n = 3'd6;
    tick();
    checks++;
    if (link_addr !== 16'h0017 || seq_err !== 1'b1) begin
      fails++;
      $display("FAIL link_bad: link=%h err=%b want 0017/1", link_addr, seq_err);
    end
  endtask

  task automatic test_loop_branch_clash();
    do_reset();
    loop_cnt_wr = 1; loop_cnt_data = 16'h5;
    jump(16'h0800);
    loop_en = 1; loop_target = 16'h0700; branch_en = 1; branch_cond = 1;
    branch_off = 8'h10;
    tick();
    pcen = 1;
    tick();
    checks++;
    if (pc !== 16'h0700 || loop_cnt !== 16'h4 || seq_err !== 1'b1) begin
      fails++;
      $display("FAIL loop_wins: pc=%h cnt=%h err=%b want 0700/0004/1",
               pc, loop_cnt, seq_err);
    end
  endtask

`ifdef FX_PC_STACK_EN
  task automatic test_stack();
    logic [15:0] exp_ret [4] = '{16'h5001, 16'h4001, 16'h3001, 16'h2001};
    do_reset();
    jump(16'h1000);
    for (int k = 0; k < 5; k++) begin
      call_en = 1; load_en = 1; load_data = 16'h2000 + 16'(k) * 16'h1000;
      tick();
    end
    checks++;
    if (pc !== 16'h6000) begin
      fails++;
      $display("FAIL call_chain: pc=%h want 6000", pc);
    end
    for (int k = 0; k < 4; k++) begin
      ret_en = 1;
      tick();
      checks++;
      if (pc !== exp_ret[k] || seq_err !== 1'b0) begin
        fails++;
        $display("FAIL ret%0d: pc=%h err=%b want %h/0", k, pc, seq_err, exp_ret[k]);
      end
    end
    ret_en = 1;
    tick();
    checks++;
    if (pc !== 16'h0000 || seq_err !== 1'b1) begin
      fails++;
      $display("FAIL ret_empty: pc=%h err=%b want 0000/1", pc, seq_err);
    end
  endtask
`else
  task automatic test_stack();
    do_reset();
    call_en = 1; load_data = 16'h0ABC;
    tick();
    checks++;
    if (pc !== 16'h0ABC) begin
      fails++;
      $display("FAIL call_as_load: pc=%h want 0ABC", pc);
    end
    ret_en = 1;
    tick();
    checks++;
    if (pc !== 16'h0ABC || seq_err !== 1'b0) begin
      fails++;
      $display("FAIL ret_ignored: pc=%h err=%b want 0ABC/0", pc, seq_err);
    end
  endtask
`endif

  initial begin
    idle_inputs();
    test_reset();
    test_async_reset();
    test_branch();
    test_loop();
    test_hold();
    test_wrap_link();
    test_loop_branch_clash();
    test_stack();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

endmodule
`default_nettype wire
